fft_radix2_core: RTL
====================

# fft_radix2_core

Iterative radix-2 DIT FFT engine that consumes the per-stage twiddle vector from the twiddle generator. It loads `FFT_LEN complex samples serially in bit-reversed order and sequences stages 0..`STG_NUM-1. For each stage it drives the stage index to the generator and performs one butterfly per cycle in place. It then streams the spectrum out in natural order. It sits between the sample source and the spectrum consumer.

## Interface
Parameters (global macros):
- `FFT_LEN`, 8, transform length (power of 2).
- `STG_NUM`, 3, log2(`FFT_LEN`).
- `STG_WID`, 2, stage index width.
- `WN_WID`, 10, signed twiddle width, Q8 (256 = 1.0).
- `DATA_WID`, 8, signed input sample width.
- Internal/output width `OW` = `DATA_WID`+`STG_NUM`.

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- start_i  in  1  start pulse; accepted only in IDLE.
- din_vld_i  in  1  input sample valid; accepted only in LOAD.
- din_re_i / din_im_i  in  `DATA_WID` each  signed input sample.
- stage_o  out  `STG_WID`  stage index to twiddle generator.
- fft_wn_re_i / fft_wn_im_i  in  `FFT_LEN`/2*`WN_WID` each  packed twiddles; slot b = bits [(b+1)*`WN_WID`-1 : b*`WN_WID`].
- dout_vld_o  out  1  output sample valid.
- dout_re_o / dout_im_o  out  `OW` each  signed spectrum sample.
- dout_idx_o  out  `STG_NUM`  bin index of dout.
- busy_o  out  1  high in LOAD/CALC/OUT.
- done_o  out  1  one-cycle completion pulse.

## Operation
- Storage: `FFT_LEN` complex registers, width `OW`; inputs are sign-extended on write.
- FSM:
  - IDLE --start_i--> LOAD.
  - LOAD: each din_vld_i writes sample n (n = count of accepted samples) to address bitrev(n). After `FFT_LEN` samples -> CALC. Gaps in din_vld_i are allowed.
  - CALC: stage s = 0..`STG_NUM`-1, butterfly b = 0..`FFT_LEN`/2-1, one per cycle.
    - half = 2^s; top = (b>>s)*2^(s+1) + (b & (half-1)); bot = top + half.
    - Twiddle is slot b of the generator output for stage_o = s.
  - After the last butterfly of the last stage -> OUT.
  - OUT: emits bins 0..`FFT_LEN`-1, one per cycle, with no backpressure. After the last bin -> IDLE with done_o = 1 for that one cycle.
- Butterfly, computed combinationally and written back at the clock edge (no read-after-write hazard):
  - P_re = B_re*W_re - B_im*W_im.
  - P_im = B_re*W_im + B_im*W_re, full precision.
  - T = P >>> 8 (see Configuration).
  - top' = A + T; bot' = A - T; truncated to `OW` (no saturation; the width provides for growth).
- stage_o = s in CALC and 0 otherwise.
- start_i outside IDLE is ignored. din_vld_i outside LOAD is ignored.

## Timing
- Reset (rst_n = 0 at an edge): state IDLE; all counters and sample registers 0; stage_o = 0, dout_vld_o = 0, dout_re/im_o = 0, dout_idx_o = 0, busy_o = 0, done_o = 0.
- Reset mid-operation aborts immediately and has the same effect.
- start_i sampled high in IDLE at edge t: busy_o = 1 from t+1.
- CALC takes exactly `STG_NUM`*`FFT_LEN`/2 cycles (12 at N=8).
- First dout_vld_o occurs on the cycle after the last CALC cycle. It stays high for `FFT_LEN` consecutive cycles with dout_idx_o = 0..`FFT_LEN`-1.
- done_o is high on the cycle after the last output. In that cycle busy_o = 0 and dout_vld_o = 0.
- start_i may be accepted in the same cycle as done_o.
- Minimum start-to-done latency: `FFT_LEN` + 12 + `FFT_LEN` + 1 cycles.

## Configuration
- `FFT_ROUND_EN` defined: T = (P + 128) >>> 8, round half up.
- `FFT_ROUND_EN` undefined: T = P >>> 8, floor truncation.

## Test plan
- Impulse x[0] = 100, others 0 -> all 8 bins re = 100, im = 0; done_o pulses once.
- DC: all x = 10 -> bin0 = (80,0), bins 1-7 = (0,0).
- Alternating: x[n] = 50*(-1)^n -> bin4 = (400,0), others (0,0).
- x[1] = 1 only:
  - With `FFT_ROUND_EN`: bin1 = (1,-1), bin5 = (-1,1).
  - Without: bin1 = (0,-1), bin5 = (0,1).
- LOAD with din_vld_i gaps (every other cycle) plus start_i pulses while busy -> results identical to the gapless run; the extra starts are ignored.
- rst_n low for one cycle in CALC stage 1 -> all outputs 0 next cycle and busy_o = 0; a following full run gives the correct impulse result.

Source files
------------

// File: rtl/fft_radix2_core.sv
// fft_radix2_core: iterative radix-2 DIT FFT; bit-reversed serial load, one in-place butterfly per cycle, natural-order output.
// Define FFT_ROUND_EN to round twiddle products half up (default: floor truncation).
`ifndef FFT_LEN
`define FFT_LEN 8
`endif
`ifndef STG_NUM
`define STG_NUM 3
`endif
`ifndef STG_WID
`define STG_WID 2
`endif
`ifndef WN_WID
`define WN_WID 10
`endif
`ifndef DATA_WID
`define DATA_WID 8
`endif

module fft_radix2_core (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 start_i,
    input  logic                                 din_vld_i,
    input  logic signed [`DATA_WID-1:0]          din_re_i,
    input  logic signed [`DATA_WID-1:0]          din_im_i,
    output logic [`STG_WID-1:0]                  stage_o,
    input  logic [`FFT_LEN/2*`WN_WID-1:0]        fft_wn_re_i,
    input  logic [`FFT_LEN/2*`WN_WID-1:0]        fft_wn_im_i,
    output logic                                 dout_vld_o,
    output logic signed [`DATA_WID+`STG_NUM-1:0] dout_re_o,
    output logic signed [`DATA_WID+`STG_NUM-1:0] dout_im_o,
    output logic [`STG_NUM-1:0]                  dout_idx_o,
    output logic                                 busy_o,
    output logic                                 done_o
);
    localparam int N  = `FFT_LEN;
    localparam int SN = `STG_NUM;
    localparam int SW = `STG_WID;
    localparam int WW = `WN_WID;
    localparam int OW = `DATA_WID + `STG_NUM;
    localparam int PW = OW + WW + 1;
    localparam int BW = SN - 1;
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOAD = 2'd1;
    localparam logic [1:0] S_CALC = 2'd2;
    localparam logic [1:0] S_OUT  = 2'd3;
`ifdef FFT_ROUND_EN
    localparam logic signed [PW-1:0] RND = PW'(128);
`else
    localparam logic signed [PW-1:0] RND = '0;
`endif

    logic [1:0]           r_state;
    logic [SN-1:0]        r_cnt;
    logic [SW-1:0]        r_stg;
    logic                 r_done;
    logic signed [OW-1:0] r_re [N];
    logic signed [OW-1:0] r_im [N];

    logic [BW-1:0]        w_b;
    logic [SN-1:0]        w_bx, w_half, w_top, w_bot;
    logic signed [WW-1:0] w_wr, w_wi;
    logic signed [OW-1:0] w_a_re, w_a_im, w_b_re, w_b_im, w_t_re, w_t_im;
    logic signed [PW-1:0] w_p_re, w_p_im;

    function automatic logic [SN-1:0] bitrev(input logic [SN-1:0] v);
        for (int i = 0; i < SN; i++) bitrev[i] = v[SN-1-i];
    endfunction

    // Butterfly addressing: top index inserts a zero at bit s of b, bot sets it.
    always_comb begin
        w_b    = r_cnt[BW-1:0];
        w_bx   = {1'b0, w_b};
        w_half = SN'(1) << r_stg;
        w_top  = (((w_bx >> r_stg) << r_stg) << 1) | (w_bx & (w_half - SN'(1)));
        w_bot  = w_top | w_half;
        w_wr   = $signed(fft_wn_re_i[w_b*WW +: WW]);
        w_wi   = $signed(fft_wn_im_i[w_b*WW +: WW]);
        w_a_re = r_re[w_top];
        w_a_im = r_im[w_top];
        w_b_re = r_re[w_bot];
        w_b_im = r_im[w_bot];
        w_p_re = PW'(w_b_re) * PW'(w_wr) - PW'(w_b_im) * PW'(w_wi) + RND;
        w_p_im = PW'(w_b_re) * PW'(w_wi) + PW'(w_b_im) * PW'(w_wr) + RND;
        w_t_re = OW'(w_p_re >>> 8);
        w_t_im = OW'(w_p_im >>> 8);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_stg   <= '0;
            r_done  <= 1'b0;
            for (int i = 0; i < N; i++) begin
                r_re[i] <= '0;
                r_im[i] <= '0;
            end
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: if (start_i) begin
                    r_state <= S_LOAD;
                    r_cnt   <= '0;
                end
                S_LOAD: if (din_vld_i) begin
                    r_re[bitrev(r_cnt)] <= OW'(din_re_i);
                    r_im[bitrev(r_cnt)] <= OW'(din_im_i);
                    r_cnt               <= r_cnt + SN'(1);
                    if (r_cnt == SN'(N - 1)) r_state <= S_CALC;
                end
                S_CALC: begin
                    r_re[w_top] <= w_a_re + w_t_re;
                    r_im[w_top] <= w_a_im + w_t_im;
                    r_re[w_bot] <= w_a_re - w_t_re;
                    r_im[w_bot] <= w_a_im - w_t_im;
                    if (&w_b) begin
                        r_cnt <= '0;
                        r_stg <= r_stg + SW'(1);
                        if (r_stg == SW'(SN - 1)) begin
                            r_state <= S_OUT;
                            r_stg   <= '0;
                        end
                    end else begin
                        r_cnt <= r_cnt + SN'(1);
                    end
                end
                default: begin
                    r_cnt <= r_cnt + SN'(1);
                    if (r_cnt == SN'(N - 1)) begin
                        r_state <= S_IDLE;
                        r_done  <= 1'b1;
                    end
                end
            endcase
        end
    end

    always_comb begin
        stage_o    = (r_state == S_CALC) ? r_stg : '0;
        dout_vld_o = r_state == S_OUT;
        dout_re_o  = dout_vld_o ? r_re[r_cnt] : '0;
        dout_im_o  = dout_vld_o ? r_im[r_cnt] : '0;
        dout_idx_o = dout_vld_o ? r_cnt : '0;
        busy_o     = r_state != S_IDLE;
        done_o     = r_done;
    end
endmodule
